btb_update_queue: RTL and testbench

Write-side controller for the branch target buffer. Collects taken-branch resolutions from several execute-stage branch ports per cycle and buffers them in a small in-order queue. Drains the queue into the BTB's single write port (`wr_en`/`wr_pc`/`wr_target`) one entry per cycle, honouring a busy back-pressure from the BTB owner. Sits between the branch units and the BTB; the BTB read path is untouched.

---
 rtl/btb_update_queue.sv | 152 +++++++++++++++
 tb/tb_btb_update_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
// In-order write queue feeding the BTB's single write port from several branch resolution ports.
// Optional build macro BTB_UPD_COALESCE_EN: same-PC resolutions update a queued entry instead of allocating.
module btb_update_queue #(
  parameter int NUM_PORTS   = 2,
  parameter int QUEUE_DEPTH = 4,
  localparam int ADDR       = 32,
  localparam int CW         = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            res_valid,
  input  logic [NUM_PORTS-1:0]            res_taken,
  input  logic [NUM_PORTS-1:0][ADDR-1:0]  res_pc,
  input  logic [NUM_PORTS-1:0][ADDR-1:0]  res_target,
  input  logic                            btb_busy,
  output logic                            wr_en,
  output logic [ADDR-1:0]                 wr_pc,
  output logic [ADDR-1:0]                 wr_target,
  output logic [CW-1:0]                   q_count,
  output logic                            full,
  output logic [15:0]                     drop_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int DW = $clog2(NUM_PORTS + 1);

  logic [ADDR-1:0]        pc_r   [QUEUE_DEPTH];
  logic [ADDR-1:0]        tgt_r  [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] vld_r;
  logic [PW-1:0]          head_r;
  logic [PW-1:0]          tail_r;
  logic [CW-1:0]          count_r;
  logic [15:0]            drop_r;

  logic [ADDR-1:0]        pc_s   [QUEUE_DEPTH];
  logic [ADDR-1:0]        tgt_s  [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] vld_s;
  logic [PW-1:0]          head_s;
  logic [PW-1:0]          tail_s;
  logic [CW-1:0]          count_s;
  logic [CW-1:0]          cap_s;
  logic [CW-1:0]          acc_s;
  logic [DW-1:0]          drop_inc_s;
  logic [16:0]            drop_sum_s;
  logic [15:0]            drop_s;
  logic                   wr_en_s;

  // Drain whenever something is queued and the BTB can take a write.
  always_comb begin
    wr_en_s = (count_r != {CW{1'b0}}) & ~btb_busy;
  end

  // Pop the head, then place candidates in port order into the slots left over.
  always_comb begin : enq_comb
`ifdef BTB_UPD_COALESCE_EN
    logic hit_v;
`endif
    logic alloc_v;
    logic [PW-1:0] slot_v;
`ifdef BTB_UPD_COALESCE_EN
    hit_v = 1'b0;
`endif
    alloc_v    = 1'b0;
    slot_v     = {PW{1'b0}};
    pc_s       = pc_r;
    tgt_s      = tgt_r;
    vld_s      = vld_r;
    acc_s      = {CW{1'b0}};
    drop_inc_s = {DW{1'b0}};
    cap_s      = CW'(QUEUE_DEPTH) - count_r + CW'(wr_en_s);
    // Clearing the popped entry first lets a push reuse its slot and hides it from coalescing.
    if (wr_en_s) begin
      vld_s[head_r] = 1'b0;
    end else begin
      vld_s[head_r] = vld_r[head_r];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      alloc_v = res_valid[i] & res_taken[i];
`ifdef BTB_UPD_COALESCE_EN
      hit_v = 1'b0;
      for (int j = 0; j < QUEUE_DEPTH; j++) begin
        if (alloc_v && vld_s[j] && (pc_s[j] == res_pc[i])) begin
          tgt_s[j] = res_target[i];
          hit_v    = 1'b1;
        end else begin
          tgt_s[j] = tgt_s[j];
        end
      end
      alloc_v = alloc_v & ~hit_v;
`endif
      slot_v = tail_r + acc_s[PW-1:0];
      if (alloc_v && (acc_s < cap_s)) begin
        pc_s[slot_v]  = res_pc[i];
        tgt_s[slot_v] = res_target[i];
        vld_s[slot_v] = 1'b1;
        acc_s         = acc_s + CW'(1);
      end else if (alloc_v) begin
        drop_inc_s = drop_inc_s + DW'(1);
      end else begin
        drop_inc_s = drop_inc_s;
      end
    end
    head_s     = head_r + PW'(wr_en_s);
    tail_s     = tail_r + acc_s[PW-1:0];
    count_s    = count_r + acc_s - CW'(wr_en_s);
    drop_sum_s = {1'b0, drop_r} + 17'(drop_inc_s);
    if (drop_sum_s[16]) begin
      drop_s = 16'hFFFF;
    end else begin
      drop_s = drop_sum_s[15:0];
    end
  end

  // Queue state registers; reset empties the queue and clears the drop counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        pc_r[k]  <= {ADDR{1'b0}};
        tgt_r[k] <= {ADDR{1'b0}};
      end
      vld_r   <= {QUEUE_DEPTH{1'b0}};
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      drop_r  <= 16'h0000;
    end else begin
      pc_r    <= pc_s;
      tgt_r   <= tgt_s;
      vld_r   <= vld_s;
      head_r  <= head_s;
      tail_r  <= tail_s;
      count_r <= count_s;
      drop_r  <= drop_s;
    end
  end

  // Head entry is shown only while the queue is non-empty.
  always_comb begin
    wr_en      = wr_en_s;
    q_count    = count_r;
    full       = (count_r == CW'(QUEUE_DEPTH));
    drop_count = drop_r;
    if (count_r != {CW{1'b0}}) begin
      wr_pc     = pc_r[head_r];
      wr_target = tgt_r[head_r];
    end else begin
      wr_pc     = {ADDR{1'b0}};
      wr_target = {ADDR{1'b0}};
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed vector bench for btb_update_queue (NUM_PORTS=2, QUEUE_DEPTH=4).
module tb_btb_update_queue;

`ifdef BTB_UPD_COALESCE_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  logic             clock;
  logic             reset_n;
  logic [1:0]       res_valid;
  logic [1:0]       res_taken;
  logic [1:0][31:0] res_pc;
  logic [1:0][31:0] res_target;
  logic             btb_busy;
  logic             wr_en;
  logic [31:0]      wr_pc;
  logic [31:0]      wr_target;
  logic [2:0]       q_count;
  logic             full;
  logic [15:0]      drop_count;

  int errors = 0;
  int checks = 0;

  btb_update_queue #(.NUM_PORTS(2), .QUEUE_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .res_valid(res_valid), .res_taken(res_taken),
    .res_pc(res_pc), .res_target(res_target), .btb_busy(btb_busy), .wr_en(wr_en),
    .wr_pc(wr_pc), .wr_target(wr_target), .q_count(q_count), .full(full),
    .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  t;
    logic [31:0] pc0, tg0, pc1, tg1;
    logic        busy;
    logic        en;
    logic [31:0] wpc, wtg;
    logic [2:0]  cnt;
    logic        full;
    logic [15:0] drop;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] t,
                              input logic [31:0] pc0, input logic [31:0] tg0,
                              input logic [31:0] pc1, input logic [31:0] tg1,
                              input logic busy, input logic en,
                              input logic [31:0] wpc, input logic [31:0] wtg,
                              input logic [2:0] cnt, input logic fl, input logic [15:0] drop);
    vec_t r;
    r.v = v; r.t = t; r.pc0 = pc0; r.tg0 = tg0; r.pc1 = pc1; r.tg1 = tg1; r.busy = busy;
    r.en = en; r.wpc = wpc; r.wtg = wtg; r.cnt = cnt; r.full = fl; r.drop = drop;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic [31:0] pc0,
                       input logic [31:0] tg0, input logic [31:0] pc1, input logic [31:0] tg1,
                       input logic busy);
    res_valid = v; res_taken = t;
    res_pc = {pc1, pc0}; res_target = {tg1, tg0};
    btb_busy = busy;
  endtask

  vec_t tbl[27];

  initial begin
    int exp_cnt;
    int exp_drop;
    int acc;
    tbl[0]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd0);
    tbl[1]  = mk(2'd1, 2'd1, 32'h100, 32'h200, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd0);
    tbl[2]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b1, 32'h100, 32'h200, 3'd1, 1'b0, 16'd0);
    tbl[3]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd0);
    tbl[4]  = mk(2'd3, 2'd3, 32'h10,  32'h40,  32'h20,  32'h80,  1'b1, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd0);
    tbl[5]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h10,  32'h40,  3'd2, 1'b0, 16'd0);
    tbl[6]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h10,  32'h40,  3'd2, 1'b0, 16'd0);
    tbl[7]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b1, 32'h10,  32'h40,  3'd2, 1'b0, 16'd0);
    tbl[8]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b1, 32'h20,  32'h80,  3'd1, 1'b0, 16'd0);
    tbl[9]  = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd0);
    tbl[10] = mk(2'd3, 2'd2, 32'h50,  32'h54,  32'h60,  32'h70,  1'b1, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd0);
    tbl[11] = mk(2'd1, 2'd2, 32'h55,  32'h56,  32'h66,  32'h67,  1'b1, 1'b0, 32'h60,  32'h70,  3'd1, 1'b0, 16'd0);
    tbl[12] = mk(2'd3, 2'd3, 32'hA0,  32'hA4,  32'hB0,  32'hB4,  1'b1, 1'b0, 32'h60,  32'h70,  3'd1, 1'b0, 16'd0);
    tbl[13] = mk(2'd3, 2'd3, 32'hC0,  32'hC4,  32'hD0,  32'hD4,  1'b1, 1'b0, 32'h60,  32'h70,  3'd3, 1'b0, 16'd0);
    tbl[14] = mk(2'd3, 2'd3, 32'hE0,  32'hE4,  32'hF0,  32'hF4,  1'b1, 1'b0, 32'h60,  32'h70,  3'd4, 1'b1, 16'd1);
    tbl[15] = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b1, 1'b0, 32'h60,  32'h70,  3'd4, 1'b1, 16'd3);
    tbl[16] = mk(2'd1, 2'd1, 32'h1F0, 32'h1F4, 32'h0,   32'h0,   1'b0, 1'b1, 32'h60,  32'h70,  3'd4, 1'b1, 16'd3);
    tbl[17] = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b1, 32'hA0,  32'hA4,  3'd4, 1'b1, 16'd3);
    tbl[18] = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b1, 32'hB0,  32'hB4,  3'd3, 1'b0, 16'd3);
    tbl[19] = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b1, 32'hC0,  32'hC4,  3'd2, 1'b0, 16'd3);
    tbl[20] = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b1, 32'h1F0, 32'h1F4, 3'd1, 1'b0, 16'd3);
    tbl[21] = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd3);
    tbl[22] = mk(2'd1, 2'd1, 32'h300, 32'h400, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd3);
    tbl[23] = mk(2'd1, 2'd1, 32'h300, 32'h500, 32'h0,   32'h0,   1'b1, 1'b0, 32'h300, 32'h400, 3'd1, 1'b0, 16'd3);
    if (CO) begin
      tbl[24] = mk(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300, 32'h500, 3'd1, 1'b0, 16'd3);
      tbl[25] = mk(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd3);
    end else begin
      tbl[24] = mk(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300, 32'h400, 3'd2, 1'b0, 16'd3);
      tbl[25] = mk(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300, 32'h500, 3'd1, 1'b0, 16'd3);
    end
    tbl[26] = mk(2'd0, 2'd0, 32'h0,   32'h0,   32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   32'h0,   3'd0, 1'b0, 16'd3);

    reset_n = 1'b0;
    drive(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Table: inputs applied at negedge, outputs sampled 1 ns later, state advances at posedge.
    for (int r = 0; r < 27; r++) begin
      drive(tbl[r].v, tbl[r].t, tbl[r].pc0, tbl[r].tg0, tbl[r].pc1, tbl[r].tg1, tbl[r].busy);
      #1;
      chk($sformatf("row%0d wr_en", r),      {31'd0, wr_en},      {31'd0, tbl[r].en});
      chk($sformatf("row%0d wr_pc", r),      wr_pc,               tbl[r].wpc);
      chk($sformatf("row%0d wr_target", r),  wr_target,           tbl[r].wtg);
      chk($sformatf("row%0d q_count", r),    {29'd0, q_count},    {29'd0, tbl[r].cnt});
      chk($sformatf("row%0d full", r),       {31'd0, full},       {31'd0, tbl[r].full});
      chk($sformatf("row%0d drop_count", r), {16'd0, drop_count}, {16'd0, tbl[r].drop});
      @(negedge clock);
    end

    // Saturation: busy held, two fresh taken resolutions every cycle.
    exp_cnt  = 0;
    exp_drop = 3;
    for (int k = 0; k < 32770; k++) begin
      drive(2'd3, 2'd3, 32'h8000_0000 + 32'(4 * k), 32'h9000_0000 + 32'(k),
            32'h8000_0002 + 32'(4 * k), 32'hA000_0000 + 32'(k), 1'b1);
      #1;
      if (k == 10) begin
        chk("sat mid drop_count", {16'd0, drop_count}, 32'(exp_drop));
        chk("sat mid q_count", {29'd0, q_count}, 32'(exp_cnt));
      end
      acc      = (4 - exp_cnt) < 2 ? (4 - exp_cnt) : 2;
      exp_cnt  = exp_cnt + acc;
      exp_drop = exp_drop + (2 - acc);
      if (exp_drop > 65535) exp_drop = 65535;
      @(negedge clock);
    end
    drive(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("sat drop_count", {16'd0, drop_count}, 32'(exp_drop));
    chk("sat drop_count is max", {16'd0, drop_count}, 32'h0000_FFFF);
    chk("sat full", {31'd0, full}, 32'd1);
    chk("sat head pc", wr_pc, 32'h8000_0000);
    chk("sat head target", wr_target, 32'h9000_0000);
    chk("sat wr_en busy", {31'd0, wr_en}, 32'd0);
    @(negedge clock);

    // Asynchronous reset while a write is being presented.
    drive(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("pre-reset wr_en", {31'd0, wr_en}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset wr_en", {31'd0, wr_en}, 32'd0);
    chk("async reset wr_pc", wr_pc, 32'h0);
    chk("async reset wr_target", wr_target, 32'h0);
    chk("async reset q_count", {29'd0, q_count}, 32'd0);
    chk("async reset drop_count", {16'd0, drop_count}, 32'd0);
    chk("async reset full", {31'd0, full}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(2'd1, 2'd1, 32'h700, 32'h704, 32'h0, 32'h0, 1'b0);
    #1;
    chk("post-reset q_count", {29'd0, q_count}, 32'd0);
    @(negedge clock);
    drive(2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("post-reset wr_en", {31'd0, wr_en}, 32'd1);
    chk("post-reset wr_pc", wr_pc, 32'h700);
    chk("post-reset wr_target", wr_target, 32'h704);
    @(negedge clock);
    #1;
    chk("post-reset drained", {29'd0, q_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
